ro_sample_packer: RTL

RO_SAMPLE_PACKER -- requirements
Module: ro_sample_packer

---
 rtl/ro_sample_packer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ro_sample_packer.sv
// ro_sample_packer
//
// Packs up to three FIFO_WIDTH-bit ring-oscillator samples into one 64-bit
// host word. Samples are popped from a show-ahead FIFO while in FILL. A word
// is presented (HOLD) once three samples are held, or earlier when a flush
// asks for a partial word. A flush that arrives while a word is held is
// remembered and applied after the word is accepted. An empty buffer never
// produces a word, so a flush with nothing collected is dropped (a remembered
// flush waits for the next sample instead).
//
// Word layout (default widths):
//   [19:0]  slot 0    [39:20] slot 1    [59:40] slot 2   (unused slots zero)
//   [61:60] sequence number (only with RO_PACK_SEQ_EN, otherwise zero)
//   [63:62] number of valid samples, 1..3
// The layout assumes 3*FIFO_WIDTH <= OUT_WIDTH-4.
//
// Configuration macro: RO_PACK_SEQ_EN -- when defined, a 2-bit sequence
// counter advances on every accepted word and is carried in bits [61:60].
//
// Ports:
//   clk           sole clock, rising edge
//   afu_rst_n     asynchronous active-low reset
//   fifo_empty    upstream FIFO empty
//   fifo_rd_data  head-of-FIFO sample, valid while fifo_empty is low
//   fifo_rd_en    pop strobe to the upstream FIFO
//   flush         single-cycle request to emit a partial word
//   out_data      packed word
//   out_valid     out_data valid
//   out_ready     downstream accepts the word when high with out_valid
//   word_count    number of words accepted since reset (wraps)

module ro_sample_packer #(
  parameter int FIFO_WIDTH  = 20,
  parameter int OUT_WIDTH   = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   afu_rst_n,
  input  logic                   fifo_empty,
  input  logic [FIFO_WIDTH-1:0]  fifo_rd_data,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] word_count
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [FIFO_WIDTH-1:0]  slot0_q, slot0_d;
  logic [FIFO_WIDTH-1:0]  slot1_q, slot1_d;
  logic [FIFO_WIDTH-1:0]  slot2_q, slot2_d;
  logic                   flushPend_q, flushPend_d;
  logic [OUT_WIDTH-1:0]   outData_q, outData_d;
  logic                   outValid_q, outValid_d;
  logic [COUNT_WIDTH-1:0] wordCount_q, wordCount_d;

  logic                   pop;
  logic [1:0]             cntNext;
  logic                   accept;
  logic [1:0]             seqField;

  // Builds the host word from the slots, the sample count and the sequence
  // number; everything not covered by a field stays zero.
  function automatic logic [OUT_WIDTH-1:0] packWord(
    input logic [1:0]            count,
    input logic [1:0]            seq,
    input logic [FIFO_WIDTH-1:0] s0,
    input logic [FIFO_WIDTH-1:0] s1,
    input logic [FIFO_WIDTH-1:0] s2
  );
    logic [OUT_WIDTH-1:0] w;
    w = '0;
    w[FIFO_WIDTH-1:0]                = s0;
    w[2*FIFO_WIDTH-1 -: FIFO_WIDTH]  = s1;
    w[3*FIFO_WIDTH-1 -: FIFO_WIDTH]  = s2;
    w[OUT_WIDTH-3 -: 2]              = seq;
    w[OUT_WIDTH-1 -: 2]              = count;
    return w;
  endfunction

  // Pops only while collecting; the reset term keeps the strobe low for the
  // whole time reset is held, not just after the next edge.
  assign pop     = (state_q == FILL) && !fifo_empty && afu_rst_n;
  assign cntNext = cnt_q + {1'b0, pop};
  assign accept  = (state_q == HOLD) && outValid_q && out_ready;

`ifdef RO_PACK_SEQ_EN
  logic [1:0] seq_q;

  // Sequence number advances once per accepted word and wraps mod 4.
  always_ff @(posedge clk or negedge afu_rst_n) begin
    if (!afu_rst_n) begin
      seq_q <= 2'd0;
    end else if (accept) begin
      seq_q <= seq_q + 2'd1;
    end
  end

  assign seqField = seq_q;
`else
  assign seqField = 2'b00;
`endif

  // Next-state logic. In FILL the popped sample goes into the slot selected
  // by the current count, and the word is built from the updated slots so a
  // pop in the same cycle as the third sample or a flush is included. A live
  // flush with nothing collected is simply ignored; a remembered flush stays
  // pending until a word actually leaves.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    slot2_d     = slot2_q;
    flushPend_d = flushPend_q;
    outData_d   = outData_q;
    outValid_d  = outValid_q;
    wordCount_d = wordCount_q;

    case (state_q)
      FILL: begin
        if (pop) begin
          case (cnt_q)
            2'd0:    slot0_d = fifo_rd_data;
            2'd1:    slot1_d = fifo_rd_data;
            default: slot2_d = fifo_rd_data;
          endcase
        end
        cnt_d = cntNext;
        if ((cntNext == 2'd3) ||
            ((flush || flushPend_q) && (cntNext != 2'd0))) begin
          state_d     = HOLD;
          outValid_d  = 1'b1;
          outData_d   = packWord(cntNext, seqField, slot0_d, slot1_d, slot2_d);
          flushPend_d = 1'b0;
        end
      end
      HOLD: begin
        if (flush) begin
          flushPend_d = 1'b1;
        end
        if (accept) begin
          state_d     = FILL;
          cnt_d       = 2'd0;
          slot0_d     = '0;
          slot1_d     = '0;
          slot2_d     = '0;
          outValid_d  = 1'b0;
          outData_d   = '0;
          wordCount_d = wordCount_q + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and output registers; reset clears the held samples and any
  // presented word at once.
  always_ff @(posedge clk or negedge afu_rst_n) begin
    if (!afu_rst_n) begin
      state_q     <= FILL;
      cnt_q       <= 2'd0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      slot2_q     <= '0;
      flushPend_q <= 1'b0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      wordCount_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      slot2_q     <= slot2_d;
      flushPend_q <= flushPend_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      wordCount_q <= wordCount_d;
    end
  end

  assign fifo_rd_en = pop;
  assign out_data   = outData_q;
  assign out_valid  = outValid_q;
  assign word_count = wordCount_q;

endmodule
